// File: rtl/trace_event_monitor.sv
// trace_event_monitor: decodes l.nop trace events per core, holds one pending event
// per core and funnels them round-robin into a first-word-fall-through event FIFO.
module trace_event_monitor #(
    parameter int NUMCORES   = 4,
    parameter int SHADOW_REG = 3,
    parameter int FIFO_DEPTH = 8,
    localparam int CW = (NUMCORES > 1) ? $clog2(NUMCORES) : 1
) (
    input  logic                     clk,
    input  logic                     rst_sys_n,
    input  logic [NUMCORES-1:0]      trace_enable,
    input  logic [32*NUMCORES-1:0]   trace_insn,
    input  logic [NUMCORES-1:0]      trace_wben,
    input  logic [5*NUMCORES-1:0]    trace_wbreg,
    input  logic [32*NUMCORES-1:0]   trace_wbdata,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [CW-1:0]            ev_core,
    output logic [1:0]               ev_code,
    output logic [31:0]              ev_data,
    output logic                     all_done,
    output logic [15:0]              drop_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = CW + 34;

    logic [31:0]         shadow [NUMCORES];
    logic [1:0]          pcode  [NUMCORES];
    logic [31:0]         pdata  [NUMCORES];
    logic [1:0]          dcode  [NUMCORES];
    logic [NUMCORES-1:0] pv, det, done;
    logic [CW-1:0]       rr, gsel;
    logic                gnt, full, pop;
    logic [AW:0]         wr_ptr, rd_ptr;
    logic [EW-1:0]       mem [FIFO_DEPTH];
    logic [4:0]          ndrop;
    logic [16:0]         dsum;
    int                  t;

    for (genvar i = 0; i < NUMCORES; i++) begin : g_det
        logic [15:0] k;
        assign k        = trace_insn[32*i +: 16];
        assign det[i]   = trace_enable[i] && trace_insn[32*i+16 +: 16] == 16'h1500 &&
                          (k == 16'd1 || k == 16'd2 || k == 16'd4);
        assign dcode[i] = k == 16'd1 ? 2'b01 : k == 16'd2 ? 2'b10 : 2'b11;
    end

    // Scan from the highest offset down so the closest pending core after rr wins.
    always_comb begin
        gnt  = 1'b0;
        gsel = '0;
        t    = 0;
        for (int k = NUMCORES - 1; k >= 0; k--) begin
            t = int'(rr) + k;
            t = (t >= NUMCORES) ? t - NUMCORES : t;
            if (pv[CW'(t)] && !full) begin
                gnt  = 1'b1;
                gsel = CW'(t);
            end
        end
    end

    always_comb begin
        ndrop = '0;
        for (int j = 0; j < NUMCORES; j++)
            ndrop = ndrop + 5'(det[j] && pv[j] && !(gnt && int'(gsel) == j));
    end

    assign dsum     = {1'b0, drop_count} + 17'(ndrop);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ev_valid = wr_ptr != rd_ptr;
    assign pop      = ev_valid && ev_ready;
    assign all_done = &done;
    assign {ev_core, ev_code, ev_data} = ev_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            pv         <= '0;
            done       <= '0;
            rr         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_count <= '0;
            for (int j = 0; j < NUMCORES; j++) begin
                shadow[j] <= '0;
                pcode[j]  <= '0;
                pdata[j]  <= '0;
            end
        end else begin
            for (int j = 0; j < NUMCORES; j++) begin
                if (trace_enable[j] && trace_wben[j] && trace_wbreg[5*j +: 5] == 5'(SHADOW_REG))
                    shadow[j] <= trace_wbdata[32*j +: 32];
                if (det[j] && (!pv[j] || (gnt && int'(gsel) == j))) begin
                    pv[j]    <= 1'b1;
                    pcode[j] <= dcode[j];
                    pdata[j] <= shadow[j];
                end else if (gnt && int'(gsel) == j) begin
                    pv[j] <= 1'b0;
                end
            end
            if (gnt) begin
                rr     <= (int'(gsel) == NUMCORES - 1) ? '0 : gsel + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
                if (pcode[gsel] == 2'b01)
                    done[gsel] <= 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            drop_count <= dsum[16] ? 16'hFFFF : dsum[15:0];
        end
    end

    always_ff @(posedge clk)
        if (gnt)
            mem[wr_ptr[AW-1:0]] <= {gsel, pcode[gsel], pdata[gsel]};
endmodule

// File: tb/tb_trace_event_monitor.sv
// tb_trace_event_monitor: directed stimulus checked every cycle against a queue-based
// model of pending slots and the event FIFO, plus literal checks for key scenarios.
module tb_trace_event_monitor;
    localparam int NC = 4;
    localparam int DEPTH = 8;

    logic          clk = 0;
    logic          rst_n;
    logic [NC-1:0] trace_enable, trace_wben;
    logic [127:0]  trace_insn, trace_wbdata;
    logic [19:0]   trace_wbreg;
    logic          ev_valid, ev_ready, all_done;
    logic [1:0]    ev_core, ev_code;
    logic [31:0]   ev_data;
    logic [15:0]   drop_count;

    int total = 0;
    int bad = 0;

    trace_event_monitor #(.NUMCORES(NC), .SHADOW_REG(3), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_sys_n(rst_n), .trace_enable(trace_enable), .trace_insn(trace_insn),
        .trace_wben(trace_wben), .trace_wbreg(trace_wbreg), .trace_wbdata(trace_wbdata),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_core(ev_core), .ev_code(ev_code),
        .ev_data(ev_data), .all_done(all_done), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {int core; int code; bit [31:0] data;} ev_t;
    ev_t      q[$];
    ev_t      mp[NC];
    bit       mpv[NC];
    bit       mdone[NC];
    bit [31:0] msh[NC];
    int       mrr = 0;
    int       mdrop = 0;

    task automatic chk(string nm, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference behaviour: free the granted slot first, then any event that still finds
    // its core's slot occupied is lost.
    always @(posedge clk or negedge rst_n) begin
        int g;
        int k;
        bit pop_e;
        if (!rst_n) begin
            q.delete();
            for (int c = 0; c < NC; c++) begin
                mpv[c] = 0;
                mdone[c] = 0;
                msh[c] = 0;
            end
            mrr = 0;
            mdrop = 0;
        end else begin
            g = -1;
            pop_e = q.size() != 0 && ev_ready;
            if (q.size() < DEPTH)
                for (int o = 0; o < NC; o++)
                    if (g < 0 && mpv[(mrr + o) % NC]) g = (mrr + o) % NC;
            if (pop_e) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back(mp[g]);
                if (mp[g].code == 1) mdone[g] = 1;
                mpv[g] = 0;
                mrr = (g + 1) % NC;
            end
            for (int c = 0; c < NC; c++) begin
                k = int'(trace_insn[32*c +: 16]);
                if (trace_enable[c] && trace_insn[32*c+16 +: 16] == 16'h1500 && (k == 1 || k == 2 || k == 4)) begin
                    if (mpv[c]) mdrop = (mdrop == 65535) ? 65535 : mdrop + 1;
                    else begin
                        mpv[c] = 1;
                        mp[c] = '{c, (k == 4) ? 3 : k, msh[c]};
                    end
                end
                if (trace_enable[c] && trace_wben[c] && trace_wbreg[5*c +: 5] == 5'd3)
                    msh[c] = trace_wbdata[32*c +: 32];
            end
        end
    end

    always @(negedge clk) begin
        chk("m_valid", ev_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("m_core", ev_core, q[0].core);
            chk("m_code", ev_code, q[0].code);
            chk("m_data", ev_data, q[0].data);
        end
        chk("m_drop", drop_count, mdrop);
        chk("m_done", all_done, mdone[0] & mdone[1] & mdone[2] & mdone[3]);
    end

    task automatic clr();
        trace_enable = '0;
        trace_insn = '0;
        trace_wben = '0;
        trace_wbreg = '0;
        trace_wbdata = '0;
    endtask

    task automatic nop(int c, int k);
        trace_enable[c] = 1'b1;
        trace_insn[32*c +: 32] = 32'h15000000 | k;
    endtask

    task automatic wb(int c, logic [31:0] d);
        trace_enable[c] = 1'b1;
        trace_wben[c] = 1'b1;
        trace_wbreg[5*c +: 5] = 5'd3;
        trace_wbdata[32*c +: 32] = d;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rst_pulse();
        #1 rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    initial begin
        clr();
        ev_ready = 1;
        rst_n = 1;
        #2 rst_n = 0;
        tick();
        tick();
        chk("rst_valid", ev_valid, 0);
        chk("rst_core", ev_core, 0);
        chk("rst_data", ev_data, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_done", all_done, 0);
        rst_n = 1;
        // single report event, two-cycle latency
        wb(1, 32'h2A);
        tick();
        clr();
        nop(1, 2);
        tick();
        clr();
        chk("lat_n1_valid", ev_valid, 0);
        tick();
        chk("lat_n2_valid", ev_valid, 1);
        chk("lat_core", ev_core, 1);
        chk("lat_code", ev_code, 2'b10);
        chk("lat_data", ev_data, 32'h2A);
        repeat (3) tick();
        // simultaneous putc on all cores from rr=0
        rst_pulse();
        for (int c = 0; c < NC; c++) nop(c, 4);
        tick();
        clr();
        tick();
        for (int c = 0; c < NC; c++) begin
            chk("rr_core", ev_core, c);
            chk("rr_code", ev_code, 2'b11);
            tick();
        end
        chk("rr_drop", drop_count, 0);
        // overflow with consumer stalled
        rst_pulse();
        ev_ready = 0;
        wb(0, 32'd99);
        tick();
        for (int i = 0; i < 10; i++) begin
            clr();
            nop(0, 2);
            wb(0, 32'(100 + i));
            tick();
        end
        clr();
        tick();
        chk("ovf_drop", drop_count, 1);
        chk("ovf_valid", ev_valid, 1);
        chk("ovf_data", ev_data, 99);
        repeat (3) tick();
        chk("ovf_stable", ev_data, 99);
        chk("ovf_code", ev_code, 2'b10);
        ev_ready = 1;
        repeat (12) tick();
        chk("ovf_drained", ev_valid, 0);
        chk("ovf_drop_kept", drop_count, 1);
        // exit on each core in turn
        rst_pulse();
        for (int c = 0; c < NC; c++) begin
            clr();
            nop(c, 1);
            tick();
        end
        clr();
        chk("done_early", all_done, 0);
        tick();
        chk("done_rise", all_done, 1);
        repeat (3) tick();
        // async reset with events queued
        ev_ready = 0;
        nop(0, 2);
        nop(1, 2);
        nop(2, 2);
        tick();
        clr();
        repeat (4) tick();
        chk("q3_valid", ev_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_valid", ev_valid, 0);
        chk("arst_drop", drop_count, 0);
        chk("arst_done", all_done, 0);
        chk("arst_core", ev_core, 0);
        tick();
        rst_n = 1;
        ev_ready = 1;
        repeat (4) tick();
        chk("arst_no_stale", ev_valid, 0);
        // ignored K values and disabled retire
        nop(0, 3);
        nop(1, 0);
        nop(2, 5);
        trace_insn[127:96] = 32'h15000001;
        tick();
        clr();
        repeat (3) tick();
        chk("ign_valid", ev_valid, 0);
        chk("ign_drop", drop_count, 0);
        nop(3, 4);
        tick();
        clr();
        chk("post_n1", ev_valid, 0);
        tick();
        chk("post_n2", ev_valid, 1);
        chk("post_core", ev_core, 3);
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
